// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one combinational ALU between two
// requesters, with latched operands and a registered result per operation.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_out
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_reg;
  logic             last_grant_reg;
  logic             owner_reg;
  logic [WIDTH-1:0] opa_reg;
  logic [WIDTH-1:0] opb_reg;
  logic [OPW-1:0]   op_reg;
  logic [WIDTH-1:0] result_reg;
  logic [1:0]       rsp_valid_reg;

  logic [1:0]       req_valid;
  logic [1:0]       rsp_ready;
  logic [1:0]       req_ready;
  logic             grant_next;
  logic             accept;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  // Contention goes to whoever was not served last; a lone requester always wins.
  always_comb begin
    grant_next = req_valid[1];
    if (req_valid == 2'b11) begin
      grant_next = ~last_grant_reg;
    end
  end

  // Gated by rst so nothing appears accepted during a reset cycle.
  assign accept = (state_reg == IDLE) && (|req_valid) && !rst;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign req_ready[gi] = accept && (grant_next == 1'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      opa_reg        <= '0;
      opb_reg        <= '0;
      op_reg         <= '0;
      result_reg     <= '0;
      rsp_valid_reg  <= 2'b00;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            opa_reg   <= grant_next ? req1_a  : req0_a;
            opb_reg   <= grant_next ? req1_b  : req0_b;
            op_reg    <= grant_next ? req1_op : req0_op;
            owner_reg <= grant_next;
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          result_reg    <= alu_out;
          rsp_valid_reg <= owner_reg ? 2'b10 : 2'b01;
          state_reg     <= RESP;
        end
        RESP: begin
          if (rsp_ready[owner_reg]) begin
            rsp_valid_reg  <= 2'b00;
            last_grant_reg <= owner_reg;
            state_reg      <= IDLE;
          end
        end
        default: begin
          rsp_valid_reg <= 2'b00;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];
  assign rsp0_valid = rsp_valid_reg[0];
  assign rsp1_valid = rsp_valid_reg[1];
  assign rsp0_data  = result_reg;
  assign rsp1_data  = result_reg;
  assign alu_a      = opa_reg;
  assign alu_b      = opb_reg;
  assign alu_op     = op_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with an adder standing in for the ALU.
module tb_alu_share_arbiter;
  localparam int WIDTH = 32;
  localparam int OPW   = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic [WIDTH-1:0] req0_a, req0_b, rsp0_data;
  logic [OPW-1:0]   req0_op;
  logic             req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [WIDTH-1:0] req1_a, req1_b, rsp1_data;
  logic [OPW-1:0]   req1_op;
  logic [WIDTH-1:0] alu_a, alu_b, alu_out;
  logic [OPW-1:0]   alu_op;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign alu_out = alu_a + alu_b;

  alu_share_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out)
  );

  task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    if (!rst && rsp0_valid && rsp0_ready) $display("txn rsp0 data=%h", rsp0_data);
    if (!rst && rsp1_valid && rsp1_ready) $display("txn rsp1 data=%h", rsp1_data);
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0; rsp0_ready = 1;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0; rsp1_ready = 1;

    // Reset state
    repeat (2) step();
    #2;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_rsp0_data", rsp0_data, 0);
    rst = 1'b0;

    // 1. Single op from requester 0
    step(); req0_valid = 1; req0_a = 2; req0_b = 2; req0_op = 5'd3; #2;
    chk("t1_req0_ready", req0_ready, 1);
    chk("t1_req1_ready", req1_ready, 0);
    step(); req0_valid = 0; #2;
    chk("t1_exec_alu_op", alu_op, 3);
    chk("t1_exec_alu_a", alu_a, 2);
    chk("t1_exec_ready", req0_ready, 0);
    chk("t1_exec_rsp0_valid", rsp0_valid, 0);
    step(); #2;
    chk("t1_rsp0_valid", rsp0_valid, 1);
    chk("t1_rsp0_data", rsp0_data, 4);
    chk("t1_rsp1_valid", rsp1_valid, 0);
    step(); #2;
    chk("t1_done_rsp0_valid", rsp0_valid, 0);

    // 2. Both requesters continuously valid from reset: 0,1,0,1
    rst = 1; repeat (2) step(); rst = 0;
    step();
    req0_valid = 1; req0_a = 10; req0_b = 1;
    req1_valid = 1; req1_a = 20; req1_b = 2;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("t2_grant0", req0_ready, (i % 2 == 0) ? 1 : 0);
      chk("t2_grant1", req1_ready, (i % 2 == 1) ? 1 : 0);
      step(); #2;
      chk("t2_exec_ready", {req1_ready, req0_ready}, 0);
      step(); #2;
      if (i % 2 == 0) begin
        chk("t2_rsp0_valid", rsp0_valid, 1);
        chk("t2_rsp0_data", rsp0_data, 11);
        chk("t2_rsp1_idle", rsp1_valid, 0);
      end else begin
        chk("t2_rsp1_valid", rsp1_valid, 1);
        chk("t2_rsp1_data", rsp1_data, 22);
        chk("t2_rsp0_idle", rsp0_valid, 0);
      end
      step();
    end
    req0_valid = 0; req1_valid = 0;

    // 3. Back-pressured response with wrap-around result
    step(); req1_valid = 1; req1_a = 32'hFFFF_FFFF; req1_b = 1; rsp1_ready = 0; #2;
    chk("t3_req1_ready", req1_ready, 1);
    step(); req1_valid = 0; req0_valid = 1; req0_a = 5; req0_b = 6; #2;
    chk("t3_exec_req0_ready", req0_ready, 0);
    for (int k = 0; k < 5; k++) begin
      step(); #2;
      chk("t3_stall_rsp1_valid", rsp1_valid, 1);
      chk("t3_stall_rsp1_data", rsp1_data, 0);
      chk("t3_stall_req0_ready", req0_ready, 0);
    end
    step(); rsp1_ready = 1; #2;
    chk("t3_hs_rsp1_valid", rsp1_valid, 1);
    chk("t3_hs_req0_ready", req0_ready, 0);
    step(); #2;
    chk("t3_after_rsp1_valid", rsp1_valid, 0);
    chk("t3_after_req0_ready", req0_ready, 1);
    step(); req0_valid = 0;
    step(); #2;
    chk("t3_rsp0_valid", rsp0_valid, 1);
    chk("t3_rsp0_data", rsp0_data, 11);
    step();

    // 4. req0 pulse while busy responding to req1
    req1_valid = 1; req1_a = 7; req1_b = 8; rsp1_ready = 0; #2;
    chk("t4_req1_ready", req1_ready, 1);
    step(); req1_valid = 0;
    step(); req0_valid = 1; #2;
    chk("t4_pulse_req0_ready", req0_ready, 0);
    step(); req0_valid = 0; #2;
    chk("t4_rsp0_valid", rsp0_valid, 0);
    chk("t4_rsp1_valid", rsp1_valid, 1);
    chk("t4_rsp1_data", rsp1_data, 15);
    rsp1_ready = 1;
    step(); #2;
    chk("t4_idle_rsp0_valid", rsp0_valid, 0);
    chk("t4_idle_rsp1_valid", rsp1_valid, 0);
    step(); #2;
    chk("t4_late_rsp0_valid", rsp0_valid, 0);

    // 5. Reset in EXEC, then in RESP
    step(); req0_valid = 1; req0_a = 3; req0_b = 4; req0_op = 5'd1; #2;
    chk("t5_req0_ready", req0_ready, 1);
    step(); req0_valid = 0; rst = 1;
    step(); rst = 0; #2;
    chk("t5_exec_rst_rsp0_valid", rsp0_valid, 0);
    chk("t5_exec_rst_alu_a", alu_a, 0);
    chk("t5_exec_rst_alu_op", alu_op, 0);
    chk("t5_exec_rst_rsp0_data", rsp0_data, 0);
    step(); #2;
    chk("t5_no_rsp0_valid", rsp0_valid, 0);
    req0_valid = 1; rsp0_ready = 0; #2;
    chk("t5_req0_ready2", req0_ready, 1);
    step(); req0_valid = 0;
    step(); #2;
    chk("t5_rsp0_valid", rsp0_valid, 1);
    chk("t5_rsp0_data", rsp0_data, 7);
    rst = 1;
    step(); rst = 0; #2;
    chk("t5_resp_rst_rsp0_valid", rsp0_valid, 0);
    chk("t5_resp_rst_rsp0_data", rsp0_data, 0);
    chk("t5_resp_rst_alu_a", alu_a, 0);
    rsp0_ready = 1;
    req1_valid = 1; req1_a = 1; req1_b = 1; req1_op = 5'd2; #2;
    chk("t5_req1_ready", req1_ready, 1);
    step(); req1_valid = 0; #2;
    chk("t5_alu_op", alu_op, 2);
    step(); #2;
    chk("t5_rsp1_valid", rsp1_valid, 1);
    chk("t5_rsp1_data", rsp1_data, 2);
    step();

    // 6. req1 alone back-to-back: accepts every third cycle
    req1_valid = 1;
    for (int i = 0; i < 3; i++) begin
      req1_a = WIDTH'(i * 100); req1_b = 5; #2;
      chk("t6_accept", req1_ready, 1);
      step(); #2;
      chk("t6_exec_ready", req1_ready, 0);
      step(); #2;
      chk("t6_rsp1_valid", rsp1_valid, 1);
      chk("t6_rsp1_data", rsp1_data, WIDTH'(i * 100 + 5));
      chk("t6_resp_ready", req1_ready, 0);
      step();
    end
    req1_valid = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
